insn_encoder_loader: RTL
========================

// Module: insn_encoder_loader
// PURPOSE
//  Inverse of the decode stage: packs MIPS field tuples (opcode/rs/rt/rd/sha/func/immed/target)
//  into 32-bit instruction words and writes them to consecutive word addresses of instruction memory.
//  Used by benches and the boot path to load a program before fetch starts.
//  One word is accepted per cycle. Each accepted word is written exactly one cycle after acceptance.
// PARAMETERS
//  BASE_ADDR    32'h80020000  byte address of the first word written in each session
//  DEPTH_WORDS  1024          maximum words per session; words beyond this are dropped
// PORTS
//  clk         in   1   single clock; all state changes on posedge
//  rst         in   1   asynchronous, active-high reset
//  start       in   1   one-cycle pulse; opens a load session (honoured only in IDLE or DONE)
//  in_valid    in   1   field tuple valid
//  in_ready    out  1   tuple accepted when in_valid && in_ready at posedge
//  fmt         in   2   0=R, 1=I, 2=J, 3=reserved
//  opcode      in   6   insn[31:26]
//  rs,rt,rd    in   5   register fields (R uses all three, I uses rs/rt)
//  sha         in   5   shift amount (R only)
//  func        in   6   function code (R only)
//  immed       in   16  immediate (I only)
//  target      in   26  jump target (J only)
//  last        in   1   tuple is the final word of the session
//  mem_addr    out  32  write byte address
//  mem_data    out  32  packed instruction word
//  mem_wren    out  1   write strobe, one cycle per word
//  mem_size    out  2   access size; constant 2'b10 (word)
//  count       out  11  words written this session
//  done        out  1   session complete; level signal
//  illegal     out  1   sticky: at least one tuple rejected as illegal
//  overflow    out  1   sticky: at least one tuple dropped because of DEPTH_WORDS
// BEHAVIOUR
//  States: IDLE -> LOAD on start; LOAD -> FLUSH on accepted last; FLUSH -> DONE after 1 cycle; DONE -> LOAD on start.
//  in_ready = (state==LOAD). It stays high when full, so the producer can drain.
//  Packing: R={opcode,rs,rt,rd,sha,func}; I={opcode,rs,rt,immed}; J={opcode,target}. Unused fields are ignored.
//  Acceptance at edge N registers mem_data and mem_addr. mem_wren is high for the cycle after edge N.
//  Back-to-back accepts produce back-to-back writes.
//  Address: first write is BASE_ADDR, then +4 per word actually written. Illegal or dropped tuples do not advance it.
//  The address never wraps. The count limit is enforced before the 32-bit address could overflow.
//  fmt==3: no write, illegal<=1. The session continues; if last is set, the session still ends.
//  count==DEPTH_WORDS at acceptance: no write, overflow<=1. last still ends the session.
//  FLUSH: in_ready=0. The last word's write completes. done rises on entry to DONE.
//  start in LOAD/FLUSH is ignored.
//  start in DONE/IDLE: count, illegal, overflow and done clear; address reloads BASE_ADDR.
//  Reset values: state=IDLE, in_ready=0, mem_wren=0, mem_addr=BASE_ADDR, mem_data=0, count=0,
//  done=0, illegal=0, overflow=0, mem_size=2'b10.
//  Reset mid-session aborts immediately. Already-written words are not undone. A pending write is lost.
// CONFIGURATION
//  INSN_ENC_CHECK_EN defined: opcode/format consistency is checked.
//   R requires opcode 6'h00 or 6'h1C; J requires opcode 6'h02 or 6'h03; I rejects 6'h00, 6'h02, 6'h03, 6'h1C.
//   A mismatch is treated exactly like fmt==3: no write, illegal<=1.
//  INSN_ENC_CHECK_EN undefined: any opcode is packed as given. illegal is set only by fmt==3.
// TESTING
//  1 start; R rs=8 rt=9 rd=10 sha=0 func=6'h20 last=0 -> next cycle mem_wren=1, addr=80020000, data=01095020.
//  2 Then I opcode=6'h09 rs=0 rt=8 immed=5, then J opcode=6'h02 target=26'h0100008 last=1, back-to-back
//    -> writes 24080005 at 80020004 and 08100008 at 80020008; done=1, count=3.
//  3 fmt=3 in the middle of 3 valid words -> 3 writes at contiguous addresses, illegal=1, count=3.
//  4 DEPTH_WORDS=2, send 3 words with the 3rd marked last -> 2 writes, overflow=1, done=1.
//  5 rst asserted asynchronously during LOAD with a write pending
//    -> mem_wren drops at once, all outputs at reset values; a new start restarts at BASE_ADDR.
//  6 With INSN_ENC_CHECK_EN: R fmt with opcode=6'h23 -> no write, illegal=1.
//    Without it: word 8D...-form written as packed.

Source files
------------

// File: rtl/insn_encoder_loader.sv
// insn_encoder_loader: packs MIPS field tuples into 32-bit words and writes them to consecutive
// word addresses from BASE_ADDR. Define INSN_ENC_CHECK_EN to reject opcode/format mismatches.
module insn_encoder_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h8002_0000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  fmt,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  sha,
    input  logic [5:0]  func,
    input  logic [15:0] immed,
    input  logic [25:0] target,
    input  logic        last,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_wren,
    output logic [1:0]  mem_size,
    output logic [10:0] count,
    output logic        done,
    output logic        illegal,
    output logic        overflow
);
    // state | meaning
    // IDLE  | out of reset, waiting for start
    // LOAD  | accepting field tuples
    // FLUSH | last tuple accepted, its write is on the bus
    // DONE  | session complete, waiting for start
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    localparam logic [10:0] COUNT_MAX = 11'(DEPTH_WORDS);

    state_t      state, state_nxt;
    logic [31:0] next_addr;
    logic [31:0] packed_word;
    logic        accept;
    logic        legal;
    logic        full;
    logic        sess_start;

    assign accept     = in_valid && (state == LOAD);
    assign sess_start = start && ((state == IDLE) || (state == DONE));
    assign full       = (count >= COUNT_MAX);
    assign mem_size   = 2'b10;

`ifdef INSN_ENC_CHECK_EN
    always_comb begin
        legal = 1'b0;
        case (fmt)
            2'd0:    legal = (opcode == 6'h00) || (opcode == 6'h1C);
            2'd1:    legal = !((opcode == 6'h00) || (opcode == 6'h02) ||
                               (opcode == 6'h03) || (opcode == 6'h1C));
            2'd2:    legal = (opcode == 6'h02) || (opcode == 6'h03);
            default: legal = 1'b0;
        endcase
    end
`else
    assign legal = (fmt != 2'd3);
`endif

    always_comb begin
        packed_word = {opcode, target};
        case (fmt)
            2'd0:    packed_word = {opcode, rs, rt, rd, sha, func};
            2'd1:    packed_word = {opcode, rs, rt, immed};
            default: packed_word = {opcode, target};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (accept && last) state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            DONE:    if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == LOAD);
        done     = (state == DONE);
    end

    // Address and count only move on words that are actually written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wren  <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_data  <= 32'h0;
            next_addr <= BASE_ADDR;
            count     <= 11'd0;
            illegal   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            mem_wren <= accept && legal && !full;
            if (sess_start) begin
                count     <= 11'd0;
                illegal   <= 1'b0;
                overflow  <= 1'b0;
                next_addr <= BASE_ADDR;
                mem_addr  <= BASE_ADDR;
            end else if (accept) begin
                if (!legal) begin
                    illegal <= 1'b1;
                end else if (full) begin
                    overflow <= 1'b1;
                end else begin
                    mem_data  <= packed_word;
                    mem_addr  <= next_addr;
                    next_addr <= next_addr + 32'd4;
                    count     <= count + 11'd1;
                end
            end
        end
    end
endmodule
